// File: rtl/set_time_ctrl.sv
// set_time_ctrl: debounced up/down/confirm controller for the set-time menu value (optional wrap via SET_TIME_WRAP_EN)
module set_time_ctrl #(
  parameter int MIN_TIME        = 30,
  parameter int MAX_TIME        = 240,
  parameter int STEP            = 15,
  parameter int DEFAULT_TIME    = 90,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  output logic [7:0] max_time,
  output logic       editing,
  output logic       time_set
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
  localparam logic [DW-1:0] DB_LIM   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LIM = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LIM  = TW'(REPEAT_CYCLES - 1);
  localparam logic [8:0] MIN9  = 9'(MIN_TIME);
  localparam logic [8:0] MAX9  = 9'(MAX_TIME);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] MIN8  = 8'(MIN_TIME);
  localparam logic [7:0] MAX8  = 8'(MAX_TIME);
  localparam logic [7:0] STEP8 = 8'(STEP);
  typedef enum logic [1:0] {IDLE, EDIT, DONE} state_t;
  state_t state, state_n;
  logic [2:0] raw, s1, s2, db, db_q, press;
  logic [DW-1:0] cnt [3];
  logic [TW-1:0] tmr;
  logic rep_act, rep_ph, up_h, dn_h, one_held, stay_edit, rep_fire, cur_press, do_step;
  logic [8:0] cur9, sum;
  logic [7:0] up_val, dn_val;
  assign raw = {btn_confirm, btn_down, btn_up};
  // Synchronize raw buttons and debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      for (int k = 0; k < 3; k++)
        if (s2[k] == db[k]) cnt[k] <= '0;
        else if (cnt[k] == DB_LIM) begin
          db[k]  <= s2[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + 1'b1;
    end
  // Press events, FSM next state, step decision and saturating/wrapping step arithmetic
  always_comb begin
    press     = db & ~db_q;
    up_h      = db[0];
    dn_h      = db[1];
    one_held  = up_h ^ dn_h;
    state_n   = state == IDLE ? (enable ? EDIT : IDLE) :
                state == EDIT ? (!enable ? IDLE : press[2] ? DONE : EDIT) :
                                (enable ? DONE : IDLE);
    stay_edit = state == EDIT && state_n == EDIT;
    rep_fire  = rep_act && tmr == (rep_ph ? REP_LIM : HOLD_LIM);
    cur_press = up_h ? press[0] : press[1];
    do_step   = stay_edit && one_held && (cur_press || rep_fire);
    cur9      = {1'b0, max_time};
    sum       = cur9 + STEP9;
`ifdef SET_TIME_WRAP_EN
    up_val    = cur9 == MAX9 ? MIN8 : sum > MAX9 ? MAX8 : sum[7:0];
    dn_val    = cur9 == MIN9 ? MAX8 : cur9 < MIN9 + STEP9 ? MIN8 : max_time - STEP8;
`else
    up_val    = sum > MAX9 ? MAX8 : sum[7:0];
    dn_val    = cur9 < MIN9 + STEP9 ? MIN8 : max_time - STEP8;
`endif
  end
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Auto-repeat timer: hold delay after a press step, then repeat period; cleared unless exactly one button held in EDIT
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rep_act <= 1'b0;
      rep_ph  <= 1'b0;
      tmr     <= '0;
    end else if (!(stay_edit && one_held)) begin
      rep_act <= 1'b0;
      rep_ph  <= 1'b0;
      tmr     <= '0;
    end else if (do_step) begin
      rep_act <= 1'b1;
      rep_ph  <= !cur_press;
      tmr     <= '0;
    end else if (rep_act) tmr <= tmr + 1'b1;
  // Registered outputs: value, editing flag, one-cycle confirm pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      max_time <= 8'(DEFAULT_TIME);
      editing  <= 1'b0;
      time_set <= 1'b0;
    end else begin
      max_time <= do_step ? (up_h ? up_val : dn_val) : max_time;
      editing  <= state_n == EDIT;
      time_set <= state == EDIT && state_n == DONE;
    end
endmodule

// File: tb/tb_set_time_ctrl.sv
// tb_set_time_ctrl: scoreboard bench for set_time_ctrl with shortened debounce/repeat timing
module tb_set_time_ctrl;
  logic clk = 0, reset = 1, enable = 0, btn_up = 0, btn_down = 0, btn_confirm = 0;
  logic [7:0] max_time;
  logic editing, time_set;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {int c; int v;} exp_t;
  exp_t q[$];
  logic [7:0] prev;
  bit mon_en = 0;

  set_time_ctrl #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .btn_up(btn_up), .btn_down(btn_down),
    .btn_confirm(btn_confirm), .max_time(max_time), .editing(editing), .time_set(time_set)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int c, int v);
    exp_t e;
    e.c = c;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic press(int b, int hold);
    if (b == 0) btn_up = 1; else btn_down = 1;
    tick(hold);
    btn_up = 0;
    btn_down = 0;
    tick(10);
  endtask

  // Every change of max_time must match the next queued expectation in value and cycle
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && max_time !== prev) begin
      if (q.size() == 0) check("spurious_change", max_time, prev);
      else begin
        e = q.pop_front();
        check("value", max_time, e.v);
        if (e.c >= 0) check("cycle", cyc, e.c);
      end
    end
    prev = max_time;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_max", max_time, 90);
    check("rst_editing", editing, 0);
    check("rst_time_set", time_set, 0);
    reset = 0;
    mon_en = 1;
    tick();
    enable = 1;
    check("editing_pre", editing, 0);
    tick();
    check("editing_rise", editing, 1);
    check("ts_idle", time_set, 0);
    check("start_max", max_time, 90);
    push(cyc + 7, 105);
    press(0, 12);
    btn_down = 1;
    tick(3);
    btn_down = 0;
    tick(10);
    check("glitch_hold", max_time, 105);
    push(cyc + 7, 90);
    press(1, 8);
    begin
      int t;
      t = cyc;
      push(t + 7, 105);
      push(t + 27, 120);
      push(t + 35, 135);
      push(t + 43, 150);
      push(t + 51, 165);
      push(t + 59, 180);
      btn_up = 1;
      tick(60);
      btn_up = 0;
      tick(12);
    end
    check("repeat_end", max_time, 180);
    for (int i = 1; i <= 10; i++) begin
      push(cyc + 7, 180 - 15 * i);
      press(1, 8);
    end
    check("at_min", max_time, 30);
`ifdef SET_TIME_WRAP_EN
    push(cyc + 7, 240);
    press(1, 8);
    check("wrap_down", max_time, 240);
    push(cyc + 7, 30);
    press(0, 8);
`else
    press(1, 8);
    check("sat_down", max_time, 30);
`endif
    for (int i = 1; i <= 6; i++) begin
      push(cyc + 7, 30 + 15 * i);
      press(0, 8);
    end
    btn_up = 1;
    btn_confirm = 1;
    tick(7);
    check("confirm_pulse", time_set, 1);
    check("confirm_editing", editing, 0);
    check("confirm_max", max_time, 120);
    tick();
    check("pulse_width", time_set, 0);
    check("done_editing", editing, 0);
    tick(5);
    btn_up = 0;
    btn_confirm = 0;
    tick(10);
    press(0, 8);
    check("done_ignore_up", max_time, 120);
    enable = 0;
    tick(2);
    check("idle_editing", editing, 0);
    enable = 1;
    tick();
    check("reenter_editing", editing, 1);
    begin
      int t;
      t = cyc;
      push(t + 7, 135);
      push(t + 27, 150);
      btn_up = 1;
      tick(32);
    end
    push(-1, 90);
    #2 reset = 1;
    #1;
    check("async_rst_max", max_time, 90);
    check("async_rst_editing", editing, 0);
    check("async_rst_ts", time_set, 0);
    btn_up = 0;
    enable = 0;
    tick(3);
    check("rst_hold_ts", time_set, 0);
    check("rst_hold_max", max_time, 90);
    reset = 0;
    tick(2);
    check("post_rst_idle", editing, 0);
    tick(3);
    check("sb_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
